// File: rtl/exp_pkg.sv
// Shared constants for the exp_process datapath and the arbiter that feeds it.
package exp_pkg;

    localparam int EXP_Q_W       = 8;
    localparam int EXP_R_W       = 26;
    localparam int EXP_QO_W      = 9;
    localparam int EXP_PIPE_LAT  = 25;
    localparam int EXP_RES_DEPTH = 4;
    localparam int EXP_ENTRY_W   = EXP_QO_W + EXP_R_W;

    // Width of a requester index; never zero, even for a single requester.
    function automatic int exp_id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/exp_res_fifo.sv
// Per-requester result FIFO: power-of-two depth, show-ahead head, async active-high reset.
module exp_res_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 35
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             valid_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_ok;

    assign pop_ok  = pop_i && (count_q != '0);
    assign valid_o = (count_q != '0);
    assign data_o  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the pointers and count alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    a_no_overflow : assert property (@(posedge clk) disable iff (rst)
        !(push_i && count_q == CNT_W'(DEPTH)));

endmodule

// File: rtl/exp_pipe_arbiter.sv
// Round-robin, credit-based sharing of one fixed-latency exp_process pipeline among NUM_REQ requesters.
// Define EXP_ARB_PERF_EN to add the perf_grants / perf_blocked counter outputs.
module exp_pipe_arbiter
    import exp_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PIPE_LAT  = EXP_PIPE_LAT,
    parameter int RES_DEPTH = EXP_RES_DEPTH
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*EXP_Q_W-1:0]    req_q,
    input  logic [NUM_REQ*EXP_R_W-1:0]    req_r,
    output logic [EXP_Q_W-1:0]            exp_q,
    output logic [EXP_R_W-1:0]            exp_r,
    input  logic [EXP_QO_W-1:0]           exp_q_o,
    input  logic [EXP_R_W-1:0]            exp_rpart,
    output logic [NUM_REQ-1:0]            res_valid,
    input  logic [NUM_REQ-1:0]            res_ready,
    output logic [NUM_REQ*EXP_QO_W-1:0]   res_q,
    output logic [NUM_REQ*EXP_R_W-1:0]    res_rpart,
    output logic                          busy
`ifdef EXP_ARB_PERF_EN
    ,
    output logic [NUM_REQ*32-1:0]         perf_grants,
    output logic [NUM_REQ*32-1:0]         perf_blocked
`endif
);

    localparam int ID_W = exp_id_w(NUM_REQ);
    localparam int CR_W = $clog2(RES_DEPTH) + 1;

    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [CR_W-1:0]     credit_q [NUM_REQ];
    logic [CR_W-1:0]     credit_d [NUM_REQ];
    logic [PIPE_LAT-1:0] tag_vld_q;
    logic [ID_W-1:0]     tag_id_q [PIPE_LAT];
    logic                grant_any;
    logic [ID_W-1:0]     grant_id;
    int                  scan_idx;
    logic [NUM_REQ-1:0]  res_pop, fifo_push;

    // NOTE: combinational blocks use blocking '=' with a default first, so no latch can be inferred.
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        scan_idx  = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            scan_idx = int'(rr_ptr_q) + k;
            if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
            // Reset suppresses grants so req_ready and exp_q/exp_r read zero while rst is high.
            if (!rst && !grant_any && req_valid[scan_idx] && credit_q[scan_idx] != '0) begin
                grant_any = 1'b1;
                grant_id  = ID_W'(scan_idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        exp_q     = '0;
        exp_r     = '0;
        if (grant_any) begin
            req_ready[grant_id] = 1'b1;
            exp_q = req_q[int'(grant_id)*EXP_Q_W +: EXP_Q_W];
            exp_r = req_r[int'(grant_id)*EXP_R_W +: EXP_R_W];
        end
    end

    assign rr_ptr_d = !grant_any                       ? rr_ptr_q :
                      (grant_id == ID_W'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    assign res_pop  = res_valid & res_ready;

    // A grant consumes a FIFO slot in advance; a pop returns it. Both at once cancel.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            credit_d[i] = credit_q[i];
            if (req_ready[i] && !res_pop[i])      credit_d[i] = credit_q[i] - 1'b1;
            else if (res_pop[i] && !req_ready[i]) credit_d[i] = credit_q[i] + 1'b1;
        end
    end

    // NOTE: all sequential state uses non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < NUM_REQ; i++) credit_q[i] <= CR_W'(RES_DEPTH);
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            tag_vld_q <= {tag_vld_q[PIPE_LAT-2:0], grant_any};
            credit_q  <= credit_d;
        end
    end

    // Tag ids are qualified by tag_vld_q, so they need no reset.
    always_ff @(posedge clk) begin
        tag_id_q[0] <= grant_id;
        for (int s = 1; s < PIPE_LAT; s++) tag_id_q[s] <= tag_id_q[s-1];
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++)
            fifo_push[i] = tag_vld_q[PIPE_LAT-1] && (tag_id_q[PIPE_LAT-1] == ID_W'(i));
    end

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_fifo
        logic [EXP_ENTRY_W-1:0] head;

        exp_res_fifo #(
            .DEPTH (RES_DEPTH),
            .WIDTH (EXP_ENTRY_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .push_i  (fifo_push[g]),
            .data_i  ({exp_q_o, exp_rpart}),
            .pop_i   (res_ready[g]),
            .data_o  (head),
            .valid_o (res_valid[g])
        );

        assign res_q[g*EXP_QO_W +: EXP_QO_W]    = head[EXP_ENTRY_W-1 -: EXP_QO_W];
        assign res_rpart[g*EXP_R_W +: EXP_R_W]  = head[EXP_R_W-1:0];
    end

    assign busy = (|tag_vld_q) || (|res_valid);

`ifdef EXP_ARB_PERF_EN
    logic [31:0] perf_grants_q  [NUM_REQ];
    logic [31:0] perf_blocked_q [NUM_REQ];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                perf_grants_q[i]  <= '0;
                perf_blocked_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_ready[i]) perf_grants_q[i] <= perf_grants_q[i] + 1'b1;
                if (req_valid[i] && credit_q[i] == '0) perf_blocked_q[i] <= perf_blocked_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            perf_grants[i*32 +: 32]  = perf_grants_q[i];
            perf_blocked[i*32 +: 32] = perf_blocked_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_exp_pipe_arbiter.sv
// Randomized bench for exp_pipe_arbiter against a queue-based reference model and a stand-in exp_process.
// Build with EXP_ARB_PERF_EN defined to also check the perf counters.
module tb_exp_pipe_arbiter;
    import exp_pkg::*;

    localparam int N     = 4;
    localparam int LAT   = EXP_PIPE_LAT;
    localparam int DEPTH = EXP_RES_DEPTH;

    logic                 clk, rst;
    logic [N-1:0]         req_valid, req_ready, res_valid, res_ready;
    logic [N*8-1:0]       req_q;
    logic [N*26-1:0]      req_r, res_rpart;
    logic [N*9-1:0]       res_q;
    logic [7:0]           exp_q;
    logic [25:0]          exp_r, exp_rpart;
    logic [8:0]           exp_q_o;
    logic                 busy;
`ifdef EXP_ARB_PERF_EN
    logic [N*32-1:0]      perf_grants, perf_blocked;
`endif

    exp_pipe_arbiter #(.NUM_REQ(N), .PIPE_LAT(LAT), .RES_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_q     (req_q),
        .req_r     (req_r),
        .exp_q     (exp_q),
        .exp_r     (exp_r),
        .exp_q_o   (exp_q_o),
        .exp_rpart (exp_rpart),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_q     (res_q),
        .res_rpart (res_rpart),
        .busy      (busy)
`ifdef EXP_ARB_PERF_EN
        ,
        .perf_grants  (perf_grants),
        .perf_blocked (perf_blocked)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for exp_process: range-reduction step, then a fixed LAT-stage delay, never reset.
    function automatic logic [34:0] exp_model(input logic [7:0] q, input logic [25:0] r);
        logic [8:0]  qo;
        logic [25:0] rp;
        if (r[25]) begin
            qo = {1'b0, q} - 9'd1;
            rp = r + 26'h0B17218;
        end else begin
            qo = {1'b0, q};
            rp = r;
        end
        return {qo, rp};
    endfunction

    logic [34:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= exp_model(exp_q, exp_r);
        for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
    assign {exp_q_o, exp_rpart} = pipe[LAT-1];

    // Reference model: credits, rotating priority, in-flight list with due edge, per-requester queues.
    typedef struct {
        int          due;
        int          id;
        logic [34:0] data;
    } flight_t;

    flight_t     flight[$];
    logic [34:0] fifo_m [N][$];
    int          credit_m [N];
    int          grants_m [N];
    int          blocked_m [N];
    int          rr_m, cyc;
    int          n_vec, n_err;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        flight.delete();
        for (int i = 0; i < N; i++) begin
            fifo_m[i].delete();
            credit_m[i]  = DEPTH;
            grants_m[i]  = 0;
            blocked_m[i] = 0;
        end
        rr_m = 0;
    endtask

    // One clock cycle: drive at the falling edge, compare 1 ns later, advance the model for the next rising edge.
    task automatic step(input logic [N-1:0] v, input logic [N-1:0] rdy, input bit keep_data);
        int          g;
        int          idx;
        logic [N-1:0] er;
        logic [34:0] head;
        flight_t     f;
        @(negedge clk);
        req_valid = v;
        res_ready = rdy;
        if (!keep_data) begin
            for (int i = 0; i < N; i++) begin
                req_q[8*i +: 8]   = 8'($urandom);
                req_r[26*i +: 26] = 26'($urandom);
            end
        end
        #1;
        g = -1;
        for (int k = 0; k < N; k++) begin
            idx = (rr_m + k) % N;
            if (g < 0 && v[idx] && credit_m[idx] > 0) g = idx;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        check("req_ready", req_ready, er);
        check("exp_q", exp_q, (g >= 0) ? req_q[8*g +: 8] : 8'd0);
        check("exp_r", exp_r, (g >= 0) ? req_r[26*g +: 26] : 26'd0);
        for (int i = 0; i < N; i++) begin
            check($sformatf("res_valid[%0d]", i), res_valid[i], fifo_m[i].size() != 0);
            if (fifo_m[i].size() != 0) begin
                head = fifo_m[i][0];
                check($sformatf("res_q[%0d]", i), res_q[9*i +: 9], head[34:26]);
                check($sformatf("res_rpart[%0d]", i), res_rpart[26*i +: 26], head[25:0]);
            end
`ifdef EXP_ARB_PERF_EN
            check($sformatf("perf_grants[%0d]", i), perf_grants[32*i +: 32], grants_m[i]);
            check($sformatf("perf_blocked[%0d]", i), perf_blocked[32*i +: 32], blocked_m[i]);
`endif
        end
        check("busy", busy, (flight.size() != 0) || (fifo_m[0].size() + fifo_m[1].size()
                                                     + fifo_m[2].size() + fifo_m[3].size() != 0));
        for (int i = 0; i < N; i++) begin
            if (v[i] && credit_m[i] == 0) blocked_m[i]++;
            if (rdy[i] && fifo_m[i].size() != 0) begin
                void'(fifo_m[i].pop_front());
                credit_m[i]++;
            end
        end
        while (flight.size() != 0 && flight[0].due == cyc) begin
            f = flight.pop_front();
            fifo_m[f.id].push_back(f.data);
        end
        if (g >= 0) begin
            credit_m[g]--;
            grants_m[g]++;
            rr_m   = (g + 1) % N;
            f.due  = cyc + LAT;
            f.id   = g;
            f.data = exp_model(req_q[8*g +: 8], req_r[26*g +: 26]);
            flight.push_back(f);
        end
        cyc++;
    endtask

    // Reset asserted mid-cycle, held two cycles, released away from the rising edge.
    task automatic pulse_reset();
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("rst_req_ready", req_ready, '0);
        check("rst_res_valid", res_valid, '0);
        check("rst_busy", busy, 1'b0);
        check("rst_exp_q", exp_q, 8'd0);
        check("rst_exp_r", exp_r, 26'd0);
        model_reset();
        repeat (2) @(negedge clk);
        req_valid = '1;
        #1;
        check("rst_hold_req_ready", req_ready, '0);
        rst       = 1'b0;
        req_valid = '0;
    endtask

    task automatic drain(input int cycles);
        for (int c = 0; c < cycles; c++) step('0, '1, 1'b0);
    endtask

    initial begin
        int cnt [N];
        int n, hits, pops;
        bit found;
        logic [N-1:0] er;
        logic [34:0] m;

        n_vec = 0;
        n_err = 0;
        cyc   = 0;
        rst       = 1'b1;
        req_valid = '1;
        res_ready = '0;
        req_q     = '0;
        req_r     = '0;
        model_reset();
        @(negedge clk);
        #1;
        check("por_req_ready", req_ready, '0);
        check("por_exp_q", exp_q, 8'd0);
        check("por_res_valid", res_valid, '0);
        check("por_busy", busy, 1'b0);
        rst       = 1'b0;
        req_valid = '0;

        // Single op on requester 0: issue, latency, result, busy after pop.
        req_q = '0;
        req_r = '0;
        req_q[7:0] = 8'd3;
        step(4'b0001, 4'b0000, 1'b1);
        check("s1_ready", req_ready, 4'b0001);
        check("s1_issue_q", exp_q, 8'd3);
        n = 0;
        found = 1'b0;
        while (!found && n < 40) begin
            step('0, '0, 1'b0);
            n++;
            if (res_valid[0]) found = 1'b1;
        end
        check("s1_latency", n, LAT + 1);
        m = exp_model(8'd3, 26'd0);
        check("s1_res_q", res_q[8:0], 9'h003);
        check("s1_res_rpart", res_rpart[25:0], m[25:0]);
        step('0, 4'b0001, 1'b0);
        check("s1_busy_before_pop", busy, 1'b1);
        step('0, '0, 1'b0);
        check("s1_busy_after_pop", busy, 1'b0);

        // All requesters saturating: strict rotation while credits last, fair shares, everything returns.
        pulse_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        pops = 0;
        for (int c = 0; c < 100; c++) begin
            step('1, '1, 1'b0);
            pops += $countones(res_valid & res_ready);
            if (c < N * DEPTH) begin
                er = '0;
                er[c % N] = 1'b1;
                check("s2_order", req_ready, er);
            end
            for (int i = 0; i < N; i++) if (req_ready[i]) cnt[i]++;
        end
        for (int i = 1; i < N; i++)
            check($sformatf("s2_fair[%0d]", i), (cnt[i] - cnt[0] <= 1) && (cnt[0] - cnt[i] <= 1), 1'b1);
        for (int c = 0; c < 40; c++) begin
            step('0, '1, 1'b0);
            pops += $countones(res_valid & res_ready);
        end
        check("s2_all_returned", pops, cnt[0] + cnt[1] + cnt[2] + cnt[3]);
        check("s2_idle", busy, 1'b0);

        // Requester 1 never pops: four accepts, then blocked while the others keep issuing.
        n = 0;
        hits = 0;
        for (int c = 0; c < 60; c++) begin
            step('1, 4'b1101, 1'b0);
            if (req_ready[1]) n++;
            if (c >= 40 && (req_ready & 4'b1101) != '0) hits++;
        end
        check("s3_accepts", n, DEPTH);
        check("s3_blocked_now", req_ready[1], 1'b0);
        check("s3_others_issue", hits > 0, 1'b1);
        step('1, '1, 1'b0);
        check("s3_pop_cycle_no_grant1", req_ready[1], 1'b0);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step('1, 4'b1101, 1'b0);
            if (req_ready[1]) n++;
        end
        check("s3_one_regrant", n, 1);
        drain(60);

        // Requester 2 at credit 1: grant and pop in the same cycle leave the credit at 1.
        for (int c = 0; c < 3; c++) step(4'b0100, '0, 1'b0);
        for (int c = 0; c < 30; c++) step('0, '0, 1'b0);
        step(4'b0100, 4'b0100, 1'b0);
        check("s4_grant", req_ready, 4'b0100);
        check("s4_pop", res_valid[2], 1'b1);
        n = 0;
        for (int c = 0; c < 30; c++) begin
            step(4'b0100, '0, 1'b0);
            if (req_ready[2]) n++;
        end
        check("s4_credit_left", n, 1);
        drain(40);

        // Random traffic.
        for (int c = 0; c < 300; c++) step(N'($urandom), N'($urandom), 1'b0);
        drain(40);

        // Reset with ten ops in flight: nothing comes back, credits restored.
        for (int c = 0; c < 10; c++) step('1, '0, 1'b0);
        pulse_reset();
        hits = 0;
        for (int c = 0; c < 30; c++) begin
            step('0, '1, 1'b0);
            if (res_valid != '0) hits++;
        end
        check("s6_no_stale_results", hits, 0);
        check("s6_idle", busy, 1'b0);
        n = 0;
        for (int c = 0; c < 8; c++) begin
            step(4'b0010, '0, 1'b0);
            if (req_ready[1]) n++;
        end
        check("s6_credits_restored", n, DEPTH);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
